telem_decoder: RTL

- Bench-side and host-side decoder for the eBike telemetry stream, sitting directly behind UART_rcv.
- Consumes received bytes, synchronises on the 0xAA/0x55 delimiter pair, and reassembles the three 12-bit payload fields (battery, average current, average torque).
- Presents each complete, validated frame atomically with a one-cycle valid strobe.
- Detects malformed frames and stalled frames, and keeps frame and error counters for self-checking benches.

---
 rtl/telem_decoder.sv | 110 +++++++++++
 1 files changed

// File: rtl/telem_decoder.sv
// eBike telemetry stream decoder: hunts for the delimiter pair, reassembles three
// 12-bit fields, and reports good frames, aborted frames and running counts.
module telem_decoder #(
  parameter int unsigned TIMEOUT = 65536,
  parameter logic [7:0]  DELIM1  = 8'hAA,
  parameter logic [7:0]  DELIM2  = 8'h55
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rdy,
  output logic        clr_rdy,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] torque,
  output logic        vld,
  output logic        frm_err,
  output logic [15:0] frm_cnt,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {HUNT1, HUNT2, BH, BL, CH, CL, TH, TL} state_t;

  state_t        state, state_n;
  logic [TW-1:0] tcnt;
  logic [11:0]   sh_b, sh_c, sh_t;
  logic          tmo, abort, done, nib_ok;

  assign clr_rdy = rdy;
  assign busy    = (state != HUNT1);
  assign nib_ok  = (rx_data[7:4] == 4'h0);
  // An accepted byte in the same cycle always beats the timeout.
  assign tmo     = (state != HUNT1) && !rdy && (tcnt == TMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT1;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    abort   = 1'b0;
    done    = 1'b0;
    if (rdy) begin
      unique case (state)
        HUNT1: if (rx_data == DELIM1) state_n = HUNT2;
        HUNT2: begin
          if (rx_data == DELIM2)      state_n = BH;
          else if (rx_data == DELIM1) state_n = HUNT2;
          else                        state_n = HUNT1;
        end
        BH: if (nib_ok) state_n = BL; else begin state_n = HUNT1; abort = 1'b1; end
        CH: if (nib_ok) state_n = CL; else begin state_n = HUNT1; abort = 1'b1; end
        TH: if (nib_ok) state_n = TL; else begin state_n = HUNT1; abort = 1'b1; end
        BL: state_n = CH;
        CL: state_n = TH;
        TL: begin state_n = HUNT1; done = 1'b1; end
        default: state_n = HUNT1;
      endcase
    end else if (tmo) begin
      // HUNT2 stalls fall back to hunting silently; mid-frame stalls are errors.
      state_n = HUNT1;
      abort   = (state != HUNT2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt    <= '0;
      sh_b    <= '0;
      sh_c    <= '0;
      sh_t    <= '0;
      batt    <= '0;
      curr    <= '0;
      torque  <= '0;
      vld     <= 1'b0;
      frm_err <= 1'b0;
      frm_cnt <= '0;
      err_cnt <= '0;
    end else begin
      vld     <= done;
      frm_err <= abort;
      if (rdy || state == HUNT1 || tmo) tcnt <= '0;
      else                              tcnt <= tcnt + 1'b1;
      if (rdy) begin
        unique case (state)
          BH: if (nib_ok) sh_b[11:8] <= rx_data[3:0];
          CH: if (nib_ok) sh_c[11:8] <= rx_data[3:0];
          TH: if (nib_ok) sh_t[11:8] <= rx_data[3:0];
          BL: sh_b[7:0] <= rx_data;
          CL: sh_c[7:0] <= rx_data;
          TL: sh_t[7:0] <= rx_data;
          default: ;
        endcase
      end
      if (done) begin
        batt    <= sh_b;
        curr    <= sh_c;
        torque  <= {sh_t[11:8], rx_data};
        frm_cnt <= frm_cnt + 16'd1;
      end
      if (abort && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
